// File: rtl/aibnd_dcc_dly_rep_cal.sv
`default_nettype none
// ============================================================================
// aibnd_dcc_dly_rep_cal : multi-channel DCC delay-replica SAR calibration
// Rev 1.0
// ============================================================================
module aibnd_dcc_dly_rep_cal #(
    parameter int NCH    = 2,
    parameter int CODE_W = 5,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        idat_i,
    input  logic                  rb_dcc_byp_i,
    input  logic                  rb_cal_en_i,
    input  logic                  rb_ovr_en_i,
    input  logic [NCH*CODE_W-1:0] rb_code_ovr_i,
    input  logic [NCH-1:0]        pd_early_i,
    output logic [NCH-1:0]        clkrep_o,
    output logic [NCH*CODE_W-1:0] dly_code_o,
    output logic                  busy_o,
    output logic                  cal_done_o,
    output logic [NCH-1:0]        cal_err_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CODE_W-1:0] c_MID       = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] c_ONES      = {CODE_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_SETTLE_M1 = CNT_W'(SETTLE - 1);

    state_t              state_q;
    logic [CODE_W-1:0]   code_q [NCH];
    logic [CODE_W-1:0]   code_d [NCH];
    logic [CODE_W-1:0]   mask_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cal_en_q;
    logic                busy_q;
    logic                done_q;
    logic [NCH-1:0]      err_q;
    logic [NCH-1:0]      err_d;
    logic                w_start;
    logic                w_abort;

    assign w_start = rb_cal_en_i & ~cal_en_q & ~rb_dcc_byp_i;
    assign w_abort = rb_dcc_byp_i | ~rb_cal_en_i;

    // Trial bit is cleared when the replica is late, then the next bit is tried.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            code_d[i] = code_q[i];
            if (!pd_early_i[i]) begin
                code_d[i] = code_d[i] & ~mask_q;
            end
            code_d[i] = code_d[i] | (mask_q >> 1);
            err_d[i]  = ((code_q[i] == c_ONES) &&  pd_early_i[i]) ||
                        ((code_q[i] == '0)     && !pd_early_i[i]);
        end
    end

    // A zero bit pointer marks the final settle window ahead of the range check.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < NCH; i++) begin
                code_q[i] <= '0;
            end
            mask_q   <= '0;
            cnt_q    <= '0;
            cal_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            cal_en_q <= rb_cal_en_i;
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        state_q <= S_SETTLE;
                        for (int i = 0; i < NCH; i++) begin
                            code_q[i] <= c_MID;
                        end
                        mask_q  <= c_MID;
                        cnt_q   <= c_SETTLE_M1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (w_abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= (mask_q == '0) ? S_CHECK : S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (w_abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        for (int i = 0; i < NCH; i++) begin
                            code_q[i] <= code_d[i];
                        end
                        mask_q  <= mask_q >> 1;
                        cnt_q   <= c_SETTLE_M1;
                        state_q <= S_SETTLE;
                    end
                end
                S_CHECK: begin
                    if (w_abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        err_q   <= err_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!rb_cal_en_i) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bypass beats override, override beats the calibrated code.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign dly_code_o[g*CODE_W +: CODE_W] =
            rb_dcc_byp_i ? '0 :
            rb_ovr_en_i  ? rb_code_ovr_i[g*CODE_W +: CODE_W] :
                           code_q[g];
    end

    assign clkrep_o   = idat_i;
    assign busy_o     = busy_q;
    assign cal_done_o = done_q;
    assign cal_err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aibnd_dcc_dly_rep_cal.sv
`default_nettype none
// ============================================================================
// tb_aibnd_dcc_dly_rep_cal : self-checking bench with SAR reference model
// Rev 1.0
// ============================================================================
module tb_aibnd_dcc_dly_rep_cal;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  idat;
    logic        rb_dcc_byp;
    logic        rb_cal_en;
    logic        rb_ovr_en;
    logic [9:0]  rb_code_ovr;
    logic [1:0]  pd_early;
    logic [1:0]  clkrep;
    logic [9:0]  dly_code;
    logic        busy;
    logic        cal_done;
    logic [1:0]  cal_err;

    int vectors    = 0;
    int miscompares = 0;
    int tgt [2];
    int mode[2];          // 0: pd = code <= target, 1: forced 1, 2: forced 0
    int trace_q[$];

    always #5 clk = ~clk;

    aibnd_dcc_dly_rep_cal #(.NCH(2), .CODE_W(5), .SETTLE(4), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .idat_i        (idat),
        .rb_dcc_byp_i  (rb_dcc_byp),
        .rb_cal_en_i   (rb_cal_en),
        .rb_ovr_en_i   (rb_ovr_en),
        .rb_code_ovr_i (rb_code_ovr),
        .pd_early_i    (pd_early),
        .clkrep_o      (clkrep),
        .dly_code_o    (dly_code),
        .busy_o        (busy),
        .cal_done_o    (cal_done),
        .cal_err_o     (cal_err)
    );

    // Phase-detector model driven from the code presented to the delay line.
    always_comb begin
        pd_early = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (mode[i] == 0) pd_early[i] = (int'(dly_code[i*5 +: 5]) <= tgt[i]);
            else              pd_early[i] = (mode[i] == 1);
        end
    end

    function automatic bit pd_of(input int m, input int t, input int code);
        if (m == 0) return (code <= t);
        return (m == 1);
    endfunction

    // Code shown on the line after k trial decisions of a binary search.
    function automatic int sar_code(input int m, input int t, input int k);
        int acc = 0;
        for (int b = 4; b > 4 - k; b--) begin
            if (pd_of(m, t, acc + (1 << b))) acc = acc + (1 << b);
        end
        if (k < 5) acc = acc + (1 << (4 - k));
        return acc;
    endfunction

    function automatic bit err_of(input int m, input int t);
        int f = sar_code(m, t, 5);
        return (f == 31 && pd_of(m, t, f)) || (f == 0 && !pd_of(m, t, f));
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cal();
        @(negedge clk);
        rb_cal_en = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic do_cal(output int lat, output logic busy1);
        trace_q.delete();
        lat   = 0;
        busy1 = 1'b0;
        @(negedge clk);
        rb_cal_en = 1'b1;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            cycle();
            if (n == 1) busy1 = busy;
            if (trace_q.size() == 0 || trace_q[$] != int'(dly_code[4:0]))
                trace_q.push_back(int'(dly_code[4:0]));
            if (cal_done) lat = n;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (dly_code !== 10'd0 || busy !== 1'b0 || cal_done !== 1'b0 || cal_err !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: code=%h busy=%b done=%b err=%b, want 0/0/0/0",
                     dly_code, busy, cal_done, cal_err);
        end
        for (int k = 0; k < 3; k++) begin
            logic [1:0] v = 2'($urandom_range(0, 3));
            idat = v;
            #1;
            vectors++;
            if (clkrep !== v) begin
                miscompares++;
                $display("FAIL clkrep_pass: got %b want %b", clkrep, v);
            end
        end
    endtask

    task automatic test_basic();
        int   lat;
        logic b1;
        int   exp_tr[5] = '{16, 24, 20, 18, 19};
        bit   ok;
        tgt[0] = 19; tgt[1] = 6; mode[0] = 0; mode[1] = 0;
        idle_cal();
        do_cal(lat, b1);
        vectors++;
        if (b1 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_start: got %b want 1", b1);
        end
        vectors++;
        if (lat != 31) begin
            miscompares++;
            $display("FAIL latency: got %0d want 31", lat);
        end
        ok = (trace_q.size() == 5);
        for (int i = 0; i < 5 && ok; i++) if (trace_q[i] != exp_tr[i]) ok = 0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ch0_sweep: got %p want 16,24,20,18,19", trace_q);
        end
        vectors++;
        if (dly_code !== {5'd6, 5'd19} || cal_err !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: code=%h err=%b busy=%b want %h/00/0",
                     dly_code, cal_err, busy, {5'd6, 5'd19});
        end
    endtask

    task automatic test_random();
        int   lat;
        logic b1;
        logic [4:0] e0, e1;
        logic [1:0] ee;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 2; i++) begin
                tgt[i]  = int'($urandom_range(0, 31));
                mode[i] = int'($urandom_range(0, 2));
            end
            e0 = 5'(sar_code(mode[0], tgt[0], 5));
            e1 = 5'(sar_code(mode[1], tgt[1], 5));
            ee = {err_of(mode[1], tgt[1]), err_of(mode[0], tgt[0])};
            idle_cal();
            do_cal(lat, b1);
            vectors++;
            if (lat != 31 || dly_code !== {e1, e0} || cal_err !== ee) begin
                miscompares++;
                $display("FAIL random_cal: lat=%0d code=%h err=%b want 31/%h/%b (tgt %0d,%0d mode %0d,%0d)",
                         lat, dly_code, cal_err, {e1, e0}, ee, tgt[0], tgt[1], mode[0], mode[1]);
            end
            repeat (5) cycle();
            vectors++;
            if (cal_done !== 1'b1 || busy !== 1'b0 || dly_code !== {e1, e0}) begin
                miscompares++;
                $display("FAIL done_hold: done=%b busy=%b code=%h want 1/0/%h",
                         cal_done, busy, dly_code, {e1, e0});
            end
            idle_cal();
            vectors++;
            if (cal_done !== 1'b0 || dly_code !== {e1, e0}) begin
                miscompares++;
                $display("FAIL done_exit: done=%b code=%h want 0/%h", cal_done, dly_code, {e1, e0});
            end
        end
    endtask

    task automatic test_saturate();
        int   lat;
        logic b1;
        mode[0] = 1; mode[1] = 2;
        idle_cal();
        do_cal(lat, b1);
        vectors++;
        if (lat != 31 || dly_code !== {5'd0, 5'd31} || cal_err !== 2'b11) begin
            miscompares++;
            $display("FAIL saturate: lat=%0d code=%h err=%b want 31/%h/11",
                     lat, dly_code, cal_err, {5'd0, 5'd31});
        end
    endtask

    task automatic test_abort();
        int   lat;
        logic b1;
        logic [9:0] held;
        tgt[0] = 19; tgt[1] = 6; mode[0] = 0; mode[1] = 0;
        held = {5'(sar_code(0, 6, 2)), 5'(sar_code(0, 19, 2))};
        idle_cal();
        @(negedge clk);
        rb_cal_en = 1'b1;
        for (int n = 1; n <= 12; n++) cycle();
        rb_cal_en = 1'b0;
        cycle();
        vectors++;
        if (busy !== 1'b0 || cal_done !== 1'b0 || dly_code !== held) begin
            miscompares++;
            $display("FAIL abort: busy=%b done=%b code=%h want 0/0/%h", busy, cal_done, dly_code, held);
        end
        repeat (3) cycle();
        vectors++;
        if (cal_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: busy=%b done=%b want 0/0", busy, cal_done);
        end
        do_cal(lat, b1);
        vectors++;
        if (b1 !== 1'b1 || trace_q.size() == 0 || trace_q[0] != 16 || lat != 31 ||
            dly_code !== {5'd6, 5'd19}) begin
            miscompares++;
            $display("FAIL restart: busy1=%b first=%0d lat=%0d code=%h want 1/16/31/%h",
                     b1, (trace_q.size() > 0) ? trace_q[0] : -1, lat, dly_code, {5'd6, 5'd19});
        end
    endtask

    task automatic test_bypass();
        logic [9:0] held;
        tgt[0] = 19; tgt[1] = 6; mode[0] = 0; mode[1] = 0;
        held = {5'(sar_code(0, 6, 1)), 5'(sar_code(0, 19, 1))};
        idle_cal();
        @(negedge clk);
        rb_cal_en = 1'b1;
        for (int n = 1; n <= 8; n++) cycle();
        rb_dcc_byp = 1'b1;
        #1;
        vectors++;
        if (dly_code !== 10'd0) begin
            miscompares++;
            $display("FAIL byp_code: got %h want 000", dly_code);
        end
        cycle();
        vectors++;
        if (busy !== 1'b0 || cal_done !== 1'b0) begin
            miscompares++;
            $display("FAIL byp_abort: busy=%b done=%b want 0/0", busy, cal_done);
        end
        rb_cal_en = 1'b0;
        cycle();
        cycle();
        rb_cal_en = 1'b1;
        repeat (3) cycle();
        rb_dcc_byp = 1'b0;
        repeat (3) cycle();
        vectors++;
        if (busy !== 1'b0 || dly_code !== held) begin
            miscompares++;
            $display("FAIL byp_nostart: busy=%b code=%h want 0/%h", busy, dly_code, held);
        end
        rb_cal_en = 1'b0;
        cycle();
    endtask

    task automatic test_override();
        int   lat;
        logic b1;
        tgt[0] = 19; tgt[1] = 6; mode[0] = 0; mode[1] = 0;
        idle_cal();
        do_cal(lat, b1);
        rb_code_ovr = {5'd29, 5'd3};
        rb_ovr_en   = 1'b1;
        #1;
        vectors++;
        if (dly_code !== {5'd29, 5'd3}) begin
            miscompares++;
            $display("FAIL ovr_on: got %h want %h", dly_code, {5'd29, 5'd3});
        end
        rb_dcc_byp = 1'b1;
        #1;
        vectors++;
        if (dly_code !== 10'd0) begin
            miscompares++;
            $display("FAIL byp_over_ovr: got %h want 000", dly_code);
        end
        rb_dcc_byp = 1'b0;
        cycle();
        rb_ovr_en = 1'b0;
        #1;
        vectors++;
        if (dly_code !== {5'd6, 5'd19} || cal_done !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_off: code=%h done=%b want %h/1", dly_code, cal_done, {5'd6, 5'd19});
        end
    endtask

    task automatic test_reset_done();
        @(negedge clk);
        reset     = 1'b1;
        rb_cal_en = 1'b0;
        cycle();
        vectors++;
        if (dly_code !== 10'd0 || busy !== 1'b0 || cal_done !== 1'b0 || cal_err !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_done: code=%h busy=%b done=%b err=%b want 0/0/0/0",
                     dly_code, busy, cal_done, cal_err);
        end
        idat = ~idat;
        #1;
        vectors++;
        if (clkrep !== idat) begin
            miscompares++;
            $display("FAIL reset_clkrep: got %b want %b", clkrep, idat);
        end
        reset = 1'b0;
        cycle();
    endtask

    initial begin
        reset = 1'b1; idat = 2'b00; rb_dcc_byp = 1'b0; rb_cal_en = 1'b0;
        rb_ovr_en = 1'b0; rb_code_ovr = '0;
        tgt[0] = 0; tgt[1] = 0; mode[0] = 0; mode[1] = 0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        test_reset();
        test_basic();
        test_random();
        test_saturate();
        test_abort();
        test_bypass();
        test_override();
        test_reset_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aibnd_dcc_dly_rep_cal.md
Name: aibnd_dcc_dly_rep_cal

Overview:
- Multi-channel, parametrised successor of the DCC delay-replica cell.
- Each of NCH channels carries a replica clock path.
- A programmable delay code per channel drives an external NAND delay line.
- A successive-approximation (SAR) calibration FSM uses a per-channel phase-detector flag to find each channel's delay code.
- Supports bypass, register override of the codes, and calibration-range error flags.
- Sits between the DCC register bank and the replica delay lines in the aibnd clock path.

Parameters:
- NCH, 2, number of replica channels.
- CODE_W, 5, delay-code width per channel (codes 0 to 2^CODE_W-1).
- SETTLE, 4, settle cycles after each code change before pd_early is sampled (must be ≥1).
- CNT_W, 4, settle-counter width (must satisfy 2^CNT_W > SETTLE).

Ports:
- clk  in  1  calibration clock.
- reset  in  1  synchronous, active-high reset.
- idat  in  NCH  replica clock inputs.
- rb_dcc_byp  in  1  bypass enable: forces zero delay code and aborts calibration.
- rb_cal_en  in  1  calibration enable (level); a rising edge starts calibration.
- rb_ovr_en  in  1  override enable: dly_code output comes from rb_code_ovr.
- rb_code_ovr  in  NCH*CODE_W  override codes; channel i occupies bits [i*CODE_W +: CODE_W].
- pd_early  in  NCH  phase-detector flag; 1 = replica early, more delay needed.
- clkrep  out  NCH  replica clock outputs.
- dly_code  out  NCH*CODE_W  delay codes to the delay lines.
- busy  out  1  calibration in progress.
- cal_done  out  1  calibration complete.
- cal_err  out  NCH  per-channel code out of range.

Behaviour:
- Clock-domain constraints:
  - clock and reset are fixed as stated: clk, synchronous active-high reset.
  - clkrep[i] = idat[i], combinational, with no clk dependence. The delay itself is applied by the external line.
  - pd_early must already be synchronous to clk.
- Reset values:
  - state IDLE
  - code registers 0
  - busy 0, cal_done 0, cal_err 0
  - rb_cal_en edge detector cleared.
- Output mux priority for dly_code:
  1. rb_dcc_byp=1 → 0
  2. else rb_ovr_en=1 → rb_code_ovr
  3. else code registers
  - Combinational; it does not disturb the FSM.
- FSM states: IDLE, SETTLE, SAMPLE, CHECK, DONE.
  - IDLE:
    - On rb_cal_en rising edge with rb_dcc_byp=0: go to SETTLE.
    - Load all codes to midscale, 1<<(CODE_W-1).
    - Set bit pointer to MSB, counter to SETTLE-1, busy=1, cal_done=0, cal_err=0.
  - SETTLE: decrement the counter; when it reaches 0, go to SAMPLE. This gives exactly SETTLE cycles.
  - SAMPLE (1 cycle), per channel:
    - If pd_early[i]=0, clear the current bit.
    - If the current bit is not the LSB, set the next-lower bit, move the pointer down, reload the counter, and return to SETTLE.
    - If the current bit is the LSB, reload the counter and go to CHECK-settle (SETTLE cycles), then CHECK.
  - CHECK (1 cycle):
    - cal_err[i] = (code==all-ones && pd_early[i]==1) || (code==0 && pd_early[i]==0).
    - Then go to DONE.
  - DONE:
    - cal_done=1, busy=0.
    - Codes and cal_err are held.
    - When rb_cal_en goes low: return to IDLE, clear cal_done, hold codes.
- Latency: start edge to cal_done high = (CODE_W+1)*(SETTLE+1)+1 cycles (31 at defaults).
- Aborts:
  - rb_cal_en=0 in any busy state → IDLE next cycle. Partial codes are held; busy=0; cal_done=0.
  - rb_dcc_byp=1 in any busy state → same abort (bypass has priority over cal_en).
- Restart: only on a fresh rising edge. A held-high rb_cal_en after DONE or an abort does not retrigger.
- Simultaneous events:
  - rb_cal_en rising together with rb_dcc_byp=1 → ignored, stay IDLE.
  - reset overrides everything.
- rb_ovr_en toggling mid-calibration: the FSM still runs on its internal codes. Only the output mux changes, and pd_early is then the bench's responsibility.
- Channels calibrate in parallel and finish in the same cycle.

Test Plan (defaults NCH=2, CODE_W=5, SETTLE=4; bench model pd_early[i] = (code_i <= target_i)):
- Reset mid-DONE → next cycle: dly_code=0, busy=0, cal_done=0, cal_err=0, clkrep follows idat.
- Targets 19 and 6, pulse rb_cal_en high → busy=1 next cycle; codes sweep 16,24,20,18,19 on ch0; cal_done at cycle 31; dly_code ch0=19, ch1=6; cal_err=00.
- pd_early forced 1 on ch0, forced 0 on ch1 → ch0 code=31, ch1 code=0; cal_err=11 at cal_done.
- rb_cal_en dropped at cycle 12 of a calibration → busy=0 next cycle, cal_done stays 0; re-raising restarts from midscale 16 and completes 31 cycles later.
- rb_dcc_byp=1 mid-calibration → dly_code=0 immediately and FSM returns to IDLE; rb_cal_en edge while bypassed → no start.
- After calibration to 19/6, set rb_ovr_en=1 with rb_code_ovr ch0=3, ch1=29 → dly_code=3/29 the same cycle; clear rb_ovr_en → 19/6 restored.
